dom_keccak_chi_seq: RTL
=======================

// Module: dom_keccak_chi_seq
// PURPOSE
//  Row-serial sequencer for the 3-share DOM Keccak chi layer.
//  - Holds one 3-share chi input state (5*W rows of 5 bits).
//  - Feeds one row at a time into a single dom_keccak_sbox instance and sources its fresh randomness.
//  - Collects the masked output rows and presents the full 3-share chi output state.
//  - Sits between the linear layer (theta/rho/pi) and iota/state register of the masked round.
// PARAMETERS
//  W        1  lane width; state = 25*W bits per share, rows = 5*W
//  SBOX_LAT 1  register latency of dom_keccak_sbox (DOM AND stage)
// PORTS
//  clk       in   1      clock
//  rst       in   1      asynchronous, active-low reset
//  start     in   1      accept new state (sampled only in IDLE)
//  sa_in     in   25*W   share A of chi input; row k = bits [5k+4:5k]
//  sb_in     in   25*W   share B of chi input
//  sc_in     in   25*W   share C of chi input
//  rnd       in   15     fresh randomness: z0=[4:0], z1=[9:5], z2=[14:10]
//  rnd_valid in   1      rnd holds fresh bits this cycle
//  rnd_req   out  1      block consumes rnd this cycle if rnd_valid
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse: result registers complete
//  out_valid out  1      sa/sb/sc_out hold a complete result
//  sa_out    out  25*W   share A of chi output
//  sb_out    out  25*W   share B of chi output
//  sc_out    out  25*W   share C of chi output
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; all outputs, share regs, z regs and counters = 0.
//  FSM states: IDLE -> (start) LOAD_ROW -> HOLD -> (last row captured) DONE -> IDLE.
//  IDLE:
//   - On start=1: latch sa/sb/sc_in into input regs, clear out_valid, row=0, go to LOAD_ROW.
//  LOAD_ROW:
//   - rnd_req=1; the sbox sees the row and rnd combinationally.
//   - rnd_valid=0: stall; row index and hold counter frozen, no capture.
//   - rnd_valid=1: latch rnd into z regs, hold_cnt=0, go to HOLD.
//  HOLD:
//   - Row inputs and latched z are held stable for SBOX_LAT further cycles, so the sbox's
//     combinational linear term and its registered DOM term refer to the same row.
//   - At the end of the last hold cycle, write ay/by/cy into row slot of sa/sb/sc_out.
//   - Then either row+1 -> LOAD_ROW, or, after row 5W-1, go to DONE.
//   - Per row: SBOX_LAT+1 cycles minimum.
//  DONE:
//   - done=1 and out_valid=1 are set on the edge that writes the last row.
//   - done lasts exactly one cycle; FSM returns to IDLE.
//   - out_valid stays 1 until the next accepted start.
//  Latency: no stalls -> done rises 5W*(SBOX_LAT+1) edges after the start-accept edge
//   (W=1, LAT=1: 10). Each stalled cycle adds exactly 1.
//  busy: 1 from the accept edge until the edge that raises done.
//  start: ignored while busy or done=1; accepted in the first IDLE cycle after done.
//  Reset mid-operation: immediate abort, all state as reset; no partial result is flagged valid.
//  Shares are never XORed together; each share path is registered separately (no unmasking).
//  Randomness: each 15-bit rnd word is consumed for exactly one row and never reused.
// STRUCTURE
//  Package keccak_dom_pkg:
//   - Constants: ROW_W=5, N_SHARES=3, RND_W=15.
//   - FSM state typedef (IDLE, LOAD_ROW, HOLD, DONE).
//  Sub-module: one dom_keccak_sbox instance, row-muxed; nothing else is instantiated.
//  Row index counter: clog2(5W) bits.
//  Hold counter: clog2(SBOX_LAT+1) bits.
// TESTING
//  1 Reset:
//    - Stimulus: assert rst=0 mid-cycle.
//    - Response: all outputs 0 immediately (async), busy=0.
//  2 Single op, W=1, LAT=1:
//    - Stimulus: sa_in=25'h0000001, sb_in=sc_in=0, rnd=0, rnd_valid=1.
//    - Response: done at edge 10; sa^sb^sc_out = 25'h0000009.
//  3 Random shares/rnd, 1000 ops:
//    - Response: XOR of outputs == golden chi(XOR of inputs);
//      individual shares differ from the unmasked result.
//  4 Stall:
//    - Stimulus: rnd_valid=0 for 3 cycles while row 2 is in LOAD_ROW.
//    - Response: done at edge 13; result identical to the unstalled run.
//  5 Start handling:
//    - Stimulus: start held high throughout an operation.
//    - Response: no effect until IDLE; back-to-back op accepted on the edge after done;
//      out_valid drops on that accept.
//  6 Abort:
//    - Stimulus: rst=0 during row 3.
//    - Response: outputs 0, out_valid=0; subsequent op yields the correct result with
//      done at edge 10.

Source files
------------

// File: rtl/dom_keccak_chi_seq_pkg.sv
// Shared constants and FSM state type for the row-serial DOM Keccak chi layer.
package keccak_dom_pkg;

    localparam int unsigned ROW_W    = 5;
    localparam int unsigned N_SHARES = 3;
    localparam int unsigned RND_W    = 15;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_ROW,
        HOLD,
        DONE
    } chi_state_t;

endpackage

// File: rtl/dom_keccak_chi_seq_sbox.sv
// Three-share DOM chi row: y_i = x_i ^ (~x_{i+1} & x_{i+2}).
// Linear term passes straight through; every AND product (inner and
// cross-domain with fresh z) is registered separately before compression.
module dom_keccak_sbox
    import keccak_dom_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] a,
    input  logic [ROW_W-1:0] b,
    input  logic [ROW_W-1:0] c,
    input  logic [RND_W-1:0] z,
    output logic [ROW_W-1:0] ay,
    output logic [ROW_W-1:0] by,
    output logic [ROW_W-1:0] cy
);

    // Term order: A-inner, A*B, A*C, B-inner, B*A, B*C, C-inner, C*A, C*B
    logic [8:0][ROW_W-1:0] terms;
    logic [8:0][ROW_W-1:0] pipe_q [SBOX_LAT];
    logic [8:0][ROW_W-1:0] last;
    logic [ROW_W-1:0]      na;
    logic [ROW_W-1:0]      z0, z1, z2;

    assign na = ~a;
    assign z0 = z[4:0];
    assign z1 = z[9:5];
    assign z2 = z[14:10];

    // Per-share partial products; each cross-domain pair shares one z bit
    always_comb begin
        terms = '0;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            terms[0][i] = na[(i+1)%ROW_W] & a[(i+2)%ROW_W];
            terms[1][i] = (na[(i+1)%ROW_W] & b[(i+2)%ROW_W]) ^ z0[i];
            terms[2][i] = (na[(i+1)%ROW_W] & c[(i+2)%ROW_W]) ^ z1[i];
            terms[3][i] = b[(i+1)%ROW_W] & b[(i+2)%ROW_W];
            terms[4][i] = (b[(i+1)%ROW_W] & a[(i+2)%ROW_W]) ^ z0[i];
            terms[5][i] = (b[(i+1)%ROW_W] & c[(i+2)%ROW_W]) ^ z2[i];
            terms[6][i] = c[(i+1)%ROW_W] & c[(i+2)%ROW_W];
            terms[7][i] = (c[(i+1)%ROW_W] & a[(i+2)%ROW_W]) ^ z1[i];
            terms[8][i] = (c[(i+1)%ROW_W] & b[(i+2)%ROW_W]) ^ z2[i];
        end
    end

    // DOM register stage(s); terms are only combined after this point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SBOX_LAT; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= terms;
            for (int unsigned s = 1; s < SBOX_LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign last = pipe_q[SBOX_LAT-1];
    assign ay   = a ^ last[0] ^ last[1] ^ last[2];
    assign by   = b ^ last[3] ^ last[4] ^ last[5];
    assign cy   = c ^ last[6] ^ last[7] ^ last[8];

endmodule

// File: rtl/dom_keccak_chi_seq.sv
// Row-serial sequencer: feeds 5*W rows of a 3-share state through one DOM
// chi sbox, sourcing one fresh 15-bit rnd word per row.
module dom_keccak_chi_seq
    import keccak_dom_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [25*W-1:0]   sa_in,
    input  logic [25*W-1:0]   sb_in,
    input  logic [25*W-1:0]   sc_in,
    input  logic [RND_W-1:0]  rnd,
    input  logic              rnd_valid,
    output logic              rnd_req,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [25*W-1:0]   sa_out,
    output logic [25*W-1:0]   sb_out,
    output logic [25*W-1:0]   sc_out
);

    localparam int unsigned ROWS   = 5 * W;
    localparam int unsigned ROW_IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HC_W   = $clog2(SBOX_LAT + 1);
    localparam logic [ROW_IW-1:0] LAST_ROW  = ROW_IW'(ROWS - 1);
    localparam logic [HC_W-1:0]   LAST_HOLD = HC_W'(SBOX_LAT - 1);

    chi_state_t        state;
    logic [25*W-1:0]   sa_q, sb_q, sc_q;
    logic [RND_W-1:0]  z_q;
    logic [RND_W-1:0]  z_sel;
    logic [ROW_IW-1:0] row;
    logic [HC_W-1:0]   hold_cnt;
    logic [ROW_W-1:0]  row_a, row_b, row_c;
    logic [ROW_W-1:0]  ay, by, cy;

    assign rnd_req = (state == LOAD_ROW);
    // Live rnd feeds the DOM register on the accept edge; the latched copy keeps it stable after
    assign z_sel   = (state == LOAD_ROW) ? rnd : z_q;

    // Select the current row of each input share
    always_comb begin
        row_a = '0;
        row_b = '0;
        row_c = '0;
        for (int unsigned k = 0; k < ROWS; k++) begin
            if (row == ROW_IW'(k)) begin
                row_a = sa_q[k*ROW_W +: ROW_W];
                row_b = sb_q[k*ROW_W +: ROW_W];
                row_c = sc_q[k*ROW_W +: ROW_W];
            end
        end
    end

    dom_keccak_sbox #(
        .SBOX_LAT (SBOX_LAT)
    ) u_sbox (
        .clk (clk),
        .rst (rst),
        .a   (row_a),
        .b   (row_b),
        .c   (row_c),
        .z   (z_sel),
        .ay  (ay),
        .by  (by),
        .cy  (cy)
    );

    // Control FSM with registered status outputs and result share registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            sc_q      <= '0;
            z_q       <= '0;
            row       <= '0;
            hold_cnt  <= '0;
            sa_out    <= '0;
            sb_out    <= '0;
            sc_out    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa_q      <= sa_in;
                        sb_q      <= sb_in;
                        sc_q      <= sc_in;
                        out_valid <= 1'b0;
                        row       <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD_ROW;
                    end
                end
                LOAD_ROW: begin
                    if (rnd_valid) begin
                        z_q      <= rnd;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == LAST_HOLD) begin
                        for (int unsigned k = 0; k < ROWS; k++) begin
                            if (row == ROW_IW'(k)) begin
                                sa_out[k*ROW_W +: ROW_W] <= ay;
                                sb_out[k*ROW_W +: ROW_W] <= by;
                                sc_out[k*ROW_W +: ROW_W] <= cy;
                            end
                        end
                        if (row == LAST_ROW) begin
                            done      <= 1'b1;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            row   <= row + 1'b1;
                            state <= LOAD_ROW;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
